// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, opcode/state enums and the single-cycle ALU for calc_engine
package calc_pkg;
  localparam int BYTE_W = 8;
  localparam int WIDTH = 16;
  localparam int DONE_LEN = 2;
  localparam int DONE_W = $clog2(DONE_LEN);
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_XOR} op_e;
  typedef enum logic [2:0] {GET_A_HI, GET_A_LO, GET_B_HI, GET_B_LO, EXEC, MUL, DONE} state_e;
  function automatic logic [WIDTH-1:0] alu(op_e op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    return op == OP_ADD ? a + b : op == OP_SUB ? a - b : a ^ b;
  endfunction
endpackage

// File: rtl/calc_if.sv
// calc_if: byte input bus (in_data/in_valid/op, driven by master) and result bus (busy/ans/done_calc, driven by slave)
interface calc_if import calc_pkg::*;;
  logic [BYTE_W-1:0] in_data;
  logic in_valid;
  logic [1:0] op;
  logic busy;
  logic [WIDTH-1:0] ans;
  logic done_calc;
  modport master(output in_data, in_valid, op, input busy, ans, done_calc);
  modport slave(input in_data, in_valid, op, output busy, ans, done_calc);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: 16-cycle LSB-first shift-add multiplier wrapping mod 2^16; ports clock, reset, start, a, b -> busy, done (last iteration), prod
module mul_seq import calc_pkg::*; (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic busy,
  output logic done,
  output logic [WIDTH-1:0] prod
);
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [3:0] iter;
  assign prod = acc + (mplier[0] ? mcand : '0);
  assign done = iter == 4'd15;
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      iter <= '0;
      busy <= 1'b0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      acc <= '0;
      iter <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= prod;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      iter <= iter + 4'd1;
      busy <= iter != 4'd15;
    end
  end
endmodule

// File: rtl/calc_engine.sv
// calc_engine: collects A/B byte-wise, computes ADD/SUB/MUL/XOR; ports clock, reset, bus (calc_if.slave: in_data, in_valid, op -> busy, ans, done_calc)
module calc_engine import calc_pkg::*; (
  input logic clock,
  input logic reset,
  calc_if.slave bus
);
  state_e state;
  op_e op_q;
  logic [WIDTH-1:0] a, b, ans_q, prod;
  logic [BYTE_W-1:0] b_hi;
  logic [DONE_W-1:0] done_cnt;
  logic done_q, busy_q, mul_busy, mul_done, take_b;
  assign take_b = state == GET_B_LO && bus.in_valid;
  assign bus.ans = ans_q;
  assign bus.done_calc = done_q;
  assign bus.busy = busy_q;
  mul_seq u_mul (
    .clock(clock),
    .reset(reset),
    .start(take_b && op_q == OP_MUL),
    .a(a),
    .b({b_hi, bus.in_data}),
    .busy(mul_busy),
    .done(mul_done),
    .prod(prod)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= GET_A_HI;
      op_q <= OP_ADD;
      a <= '0;
      b <= '0;
      b_hi <= '0;
      ans_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      done_cnt <= '0;
    end else begin
      case (state)
        GET_A_HI: if (bus.in_valid) begin
          a[15:8] <= bus.in_data;
          op_q <= op_e'(bus.op);
          state <= GET_A_LO;
        end
        GET_A_LO: if (bus.in_valid) begin
          a[7:0] <= bus.in_data;
          state <= GET_B_HI;
        end
        GET_B_HI: if (bus.in_valid) begin
          b_hi <= bus.in_data;
          state <= GET_B_LO;
        end
        GET_B_LO: if (take_b) begin
          b <= {b_hi, bus.in_data};
          busy_q <= 1'b1;
          state <= op_q == OP_MUL ? MUL : EXEC;
        end
        EXEC: begin
          ans_q <= alu(op_q, a, b);
          done_q <= 1'b1;
          done_cnt <= DONE_W'(DONE_LEN - 1);
          state <= DONE;
        end
        MUL: if (mul_busy && mul_done) begin
          ans_q <= prod;
          done_q <= 1'b1;
          done_cnt <= DONE_W'(DONE_LEN - 1);
          state <= DONE;
        end
        DONE: if (done_cnt == '0) begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state <= GET_A_HI;
        end else begin
          done_cnt <= done_cnt - 1'b1;
        end
        default: state <= GET_A_HI;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: randomized and directed checks of calc_engine against a plain-arithmetic reference model
module tb_calc_engine;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  calc_if bus();
  calc_engine dut(.clock(clock), .reset(reset), .bus(bus));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] model(logic [1:0] op, logic [15:0] a, logic [15:0] b);
    logic [31:0] r;
    r = op == 2'd0 ? a + b : op == 2'd1 ? a - b + 32'h10000 : op == 2'd2 ? a * b : a ^ b;
    return r[15:0];
  endfunction
  task automatic send_op(logic [1:0] op, logic [15:0] a, logic [15:0] b, int gap);
    logic [7:0] by [4];
    by = '{a[15:8], a[7:0], b[15:8], b[7:0]};
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(gap, 0)) begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'($urandom);
        bus.op = 2'($urandom);
        @(negedge clock);
      end
      bus.in_valid = 1'b1;
      bus.in_data = by[i];
      bus.op = i == 0 ? op : 2'($urandom);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic await_result(string tag, logic [1:0] op, logic [15:0] exp, bit junk);
    int first = -1;
    int cnt = 0;
    logic [7:0] hi = 8'h00;
    logic [7:0] lo = 8'h00;
    chk({tag, "_busy_rise"}, bus.busy, 1);
    for (int n = 1; n <= 60; n++) begin
      bus.in_valid = junk ? 1'($urandom) : 1'b0;
      bus.in_data = 8'($urandom);
      @(negedge clock);
      if (bus.done_calc) begin
        if (cnt == 0) begin
          first = n;
          hi = bus.ans[15:8];
        end else if (cnt == 1) lo = bus.ans[7:0];
        cnt++;
        chk({tag, "_ans_win"}, bus.ans, exp);
      end else if (cnt > 0) break;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_latency"}, first, op == 2'd2 ? 16 : 1);
    chk({tag, "_done_len"}, cnt, 2);
    chk({tag, "_hi"}, hi, exp[15:8]);
    chk({tag, "_lo"}, lo, exp[7:0]);
    chk({tag, "_busy_fall"}, bus.busy, 0);
    chk({tag, "_ans_hold"}, bus.ans, exp);
  endtask
  typedef struct {logic [1:0] op; logic [15:0] a, b, exp;} vec_t;
  vec_t dir [5] = '{
    '{2'd0, 16'h1234, 16'h0F0F, 16'h2143},
    '{2'd1, 16'h0001, 16'h0002, 16'hFFFF},
    '{2'd3, 16'hF0F0, 16'hFF00, 16'h0FF0},
    '{2'd2, 16'h0123, 16'h0045, 16'h4E6F},
    '{2'd2, 16'hFFFF, 16'hFFFF, 16'h0001}
  };
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.op = 2'd0;
    repeat (3) @(negedge clock);
    chk("rst_ans", bus.ans, 0);
    chk("rst_done", bus.done_calc, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    @(negedge clock);
    foreach (dir[i]) begin
      send_op(dir[i].op, dir[i].a, dir[i].b, 0);
      await_result("dir", dir[i].op, dir[i].exp, 1'b0);
    end
    foreach (dir[i]) begin
      send_op(dir[i].op, dir[i].a, dir[i].b, 5);
      await_result("gap", dir[i].op, dir[i].exp, 1'b1);
    end
    send_op(2'd2, 16'h0123, 16'h0045, 0);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mul_done", bus.done_calc, 0);
    chk("rst_mul_ans", bus.ans, 0);
    chk("rst_mul_busy", bus.busy, 0);
    reset = 1'b0;
    send_op(2'd0, 16'h0001, 16'h0001, 0);
    await_result("post_mul_rst", 2'd0, 16'h0002, 1'b0);
    send_op(2'd0, 16'h1234, 16'h0F0F, 0);
    @(negedge clock);
    chk("pre_rst_done", bus.done_calc, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_done_done", bus.done_calc, 0);
    chk("rst_done_ans", bus.ans, 0);
    reset = 1'b0;
    send_op(2'd0, 16'h0001, 16'h0001, 0);
    await_result("post_done_rst", 2'd0, 16'h0002, 1'b0);
    for (int k = 0; k < 24; k++) begin
      logic [1:0] op;
      logic [15:0] a, b;
      op = 2'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      send_op(op, a, b, k % 3);
      await_result("rand", op, model(op, a, b), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
